// File: rtl/acc_exec_ctrl.sv
// Execute/writeback stage of the accumulator processor: issues one decoded
// instruction at a time to an external combinational ALU and owns acc, flags and the store port.
module acc_exec_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [3:0]   opcode,
   input  logic [N-1:0] operand,
   output logic [N-1:0] alu_in0,
   output logic [N-1:0] alu_in1,
   output logic         alu_cin,
   output logic [2:0]   alu_ctrl,
   input  logic [N-1:0] alu_out,
   input  logic         alu_cout,
   input  logic         alu_v,
   input  logic         alu_z,
   output logic [N-1:0] acc,
   output logic         flag_c,
   output logic         flag_v,
   output logic         flag_z,
   output logic         st_valid,
   output logic [N-1:0] st_data,
   input  logic         st_ready,
   output logic         illegal
);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_STA = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_ADC = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_CLC = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_STORE = 2'd2
   } state_t;

   state_t       r_state;
   logic         r_op_ready;
   logic [N-1:0] r_acc;
   logic         r_flag_c;
   logic         r_flag_v;
   logic         r_flag_z;
   logic         r_st_valid;
   logic [N-1:0] r_st_data;
   logic         r_illegal;
   logic [N-1:0] r_alu_in1;
   logic [2:0]   r_alu_ctrl;
   logic         r_alu_cin;
   logic         r_arith;

   logic         w_is_alu;
   logic         w_is_arith;
   logic [2:0]   w_ctrl;
   logic [N-1:0] w_in1;
   logic         w_cin;
   logic         w_accept;

   assign w_accept = op_valid && r_op_ready;

   // Decode of the offered opcode into the ALU drive captured at handshake.
   always_comb begin
      w_is_alu   = 1'b0;
      w_is_arith = 1'b0;
      w_ctrl     = 3'b000;
      w_in1      = operand;
      w_cin      = 1'b0;
      case (opcode)
         OP_ADD: begin
            w_is_alu   = 1'b1;
            w_is_arith = 1'b1;
         end
         OP_ADC: begin
            w_is_alu   = 1'b1;
            w_is_arith = 1'b1;
            w_cin      = r_flag_c;
         end
         OP_SUB: begin
            w_is_alu   = 1'b1;
            w_is_arith = 1'b1;
            w_ctrl     = 3'b001;
            w_cin      = 1'b1;
         end
         OP_OR: begin
            w_is_alu = 1'b1;
            w_ctrl   = 3'b010;
         end
         OP_AND: begin
            w_is_alu = 1'b1;
            w_ctrl   = 3'b100;
         end
         OP_NOT: begin
            w_is_alu = 1'b1;
            w_ctrl   = 3'b110;
         end
         OP_SHL: begin
            w_is_alu   = 1'b1;
            w_is_arith = 1'b1;
            w_in1      = r_acc;
         end
         default: begin
            w_is_alu = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_op_ready <= 1'b0;
         r_acc      <= '0;
         r_flag_c   <= 1'b0;
         r_flag_v   <= 1'b0;
         r_flag_z   <= 1'b0;
         r_st_valid <= 1'b0;
         r_st_data  <= '0;
         r_illegal  <= 1'b0;
         r_alu_in1  <= '0;
         r_alu_ctrl <= 3'b000;
         r_alu_cin  <= 1'b0;
         r_arith    <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_op_ready <= 1'b1;
               if (w_accept) begin
                  if (w_is_alu) begin
                     r_state    <= S_EXEC;
                     r_op_ready <= 1'b0;
                     r_alu_in1  <= w_in1;
                     r_alu_ctrl <= w_ctrl;
                     r_alu_cin  <= w_cin;
                     r_arith    <= w_is_arith;
                  end else begin
                     case (opcode)
                        OP_NOP: r_acc <= r_acc;
                        OP_LDA: begin
                           r_acc    <= operand;
                           r_flag_z <= (operand == '0);
                        end
                        OP_STA: begin
                           r_state    <= S_STORE;
                           r_op_ready <= 1'b0;
                           r_st_valid <= 1'b1;
                           r_st_data  <= r_acc;
                        end
                        OP_CLC: r_flag_c <= 1'b0;
                        default: r_illegal <= 1'b1;
                     endcase
                  end
               end
            end
            S_EXEC: begin
               // Logic ops leave C and V untouched.
               r_acc    <= alu_out;
               r_flag_z <= alu_z;
               if (r_arith) begin
                  r_flag_c <= alu_cout;
                  r_flag_v <= alu_v;
               end
               r_alu_in1  <= '0;
               r_alu_ctrl <= 3'b000;
               r_alu_cin  <= 1'b0;
               r_state    <= S_IDLE;
               r_op_ready <= 1'b1;
            end
            S_STORE: begin
               if (st_ready) begin
                  r_st_valid <= 1'b0;
                  r_state    <= S_IDLE;
                  r_op_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_op_ready <= 1'b1;
               r_st_valid <= 1'b0;
            end
         endcase
      end
   end

   assign op_ready = r_op_ready;
   assign alu_in0  = r_acc;
   assign alu_in1  = r_alu_in1;
   assign alu_cin  = r_alu_cin;
   assign alu_ctrl = r_alu_ctrl;
   assign acc      = r_acc;
   assign flag_c   = r_flag_c;
   assign flag_v   = r_flag_v;
   assign flag_z   = r_flag_z;
   assign st_valid = r_st_valid;
   assign st_data  = r_st_data;
   assign illegal  = r_illegal;

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Scoreboard bench for acc_exec_ctrl: an ISA-level reference model predicts acc/flags/store
// data per instruction; a small behavioural ALU stands in for alu_nbit.
module tb_acc_exec_ctrl;

   localparam int N = 4;
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_STA = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_ADC = 4'd4;
   localparam logic [3:0] OP_SUB = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_AND = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_CLC = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;

   typedef struct packed {
      logic [N-1:0] acc;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         op_valid;
   logic         op_ready;
   logic [3:0]   opcode;
   logic [N-1:0] operand;
   logic [N-1:0] alu_in0;
   logic [N-1:0] alu_in1;
   logic         alu_cin;
   logic [2:0]   alu_ctrl;
   logic [N-1:0] w_alu_out;
   logic         w_alu_cout;
   logic         w_alu_v;
   logic         w_alu_z;
   logic [N-1:0] acc;
   logic         flag_c;
   logic         flag_v;
   logic         flag_z;
   logic         st_valid;
   logic [N-1:0] st_data;
   logic         st_ready;
   logic         illegal;

   int           checks;
   int           errors;
   exp_t         m_state;
   exp_t         sb_q[$];
   logic [N-1:0] st_q[$];
   logic [N-1:0] st_exp;
   logic [N:0]   w_alu_wide;

   acc_exec_ctrl #(.N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .opcode   (opcode),
      .operand  (operand),
      .alu_in0  (alu_in0),
      .alu_in1  (alu_in1),
      .alu_cin  (alu_cin),
      .alu_ctrl (alu_ctrl),
      .alu_out  (w_alu_out),
      .alu_cout (w_alu_cout),
      .alu_v    (w_alu_v),
      .alu_z    (w_alu_z),
      .acc      (acc),
      .flag_c   (flag_c),
      .flag_v   (flag_v),
      .flag_z   (flag_z),
      .st_valid (st_valid),
      .st_data  (st_data),
      .st_ready (st_ready),
      .illegal  (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural alu_nbit: add, subtract (in0 + ~in1 + cin), OR, AND, NOT in0.
   always_comb begin
      w_alu_wide = '0;
      w_alu_out  = '0;
      w_alu_cout = 1'b0;
      w_alu_v    = 1'b0;
      case (alu_ctrl)
         3'b000: begin
            w_alu_wide = {1'b0, alu_in0} + {1'b0, alu_in1} + {{N{1'b0}}, alu_cin};
            w_alu_out  = w_alu_wide[N-1:0];
            w_alu_cout = w_alu_wide[N];
            w_alu_v    = (alu_in0[N-1] == alu_in1[N-1]) && (w_alu_out[N-1] != alu_in0[N-1]);
         end
         3'b001: begin
            w_alu_wide = {1'b0, alu_in0} + {1'b0, ~alu_in1} + {{N{1'b0}}, alu_cin};
            w_alu_out  = w_alu_wide[N-1:0];
            w_alu_cout = w_alu_wide[N];
            w_alu_v    = (alu_in0[N-1] != alu_in1[N-1]) && (w_alu_out[N-1] != alu_in0[N-1]);
         end
         3'b010: w_alu_out = alu_in0 | alu_in1;
         3'b100: w_alu_out = alu_in0 & alu_in1;
         3'b110: w_alu_out = ~alu_in0;
         default: w_alu_out = '0;
      endcase
      w_alu_z = (w_alu_out == '0);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Architectural effect of one instruction, written from the opcode definitions.
   function automatic exp_t ref_step(input exp_t s, input logic [3:0] op, input logic [N-1:0] val);
      exp_t         r;
      logic [N:0]   wide;
      logic [N-1:0] b;
      logic         cin;
      r    = s;
      b    = (op == OP_SHL) ? s.acc : val;
      cin  = (op == OP_ADC) ? s.c : 1'b0;
      wide = '0;
      case (op)
         OP_LDA: begin
            r.acc = val;
            r.z   = (val == '0);
         end
         OP_ADD, OP_ADC, OP_SHL: begin
            wide  = {1'b0, s.acc} + {1'b0, b} + {{N{1'b0}}, cin};
            r.acc = wide[N-1:0];
            r.c   = wide[N];
            r.v   = (s.acc[N-1] == b[N-1]) && (r.acc[N-1] != s.acc[N-1]);
            r.z   = (r.acc == '0);
         end
         OP_SUB: begin
            wide  = {1'b0, s.acc} - {1'b0, val};
            r.acc = wide[N-1:0];
            r.c   = ~wide[N];
            r.v   = (s.acc[N-1] != val[N-1]) && (r.acc[N-1] != s.acc[N-1]);
            r.z   = (r.acc == '0);
         end
         OP_OR: begin
            r.acc = s.acc | val;
            r.z   = (r.acc == '0);
         end
         OP_AND: begin
            r.acc = s.acc & val;
            r.z   = (r.acc == '0);
         end
         OP_NOT: begin
            r.acc = ~s.acc;
            r.z   = (r.acc == '0);
         end
         OP_CLC: r.c = 1'b0;
         default: r = s;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] ctrl_of(input logic [3:0] op);
      case (op)
         OP_SUB: return 3'b001;
         OP_OR:  return 3'b010;
         OP_AND: return 3'b100;
         OP_NOT: return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   // Store sink: every accepted store must match the acc value captured at STA issue.
   always @(posedge clk) begin
      if (rst_n && st_valid && st_ready) begin
         check_val("st_pending", 32'(st_q.size() > 0), 32'd1);
         if (st_q.size() > 0) begin
            st_exp = st_q.pop_front();
            check_val("st_data_out", 32'(st_data), 32'(st_exp));
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [N-1:0] val);
      exp_t pre;
      exp_t e;
      int   waitc;
      logic is_alu;
      waitc = 0;
      while (op_ready !== 1'b1 && waitc < 50) begin
         @(posedge clk);
         #1;
         waitc++;
      end
      check_val("issue_ready", 32'(op_ready), 32'd1);
      pre     = m_state;
      m_state = ref_step(pre, op, val);
      sb_q.push_back(m_state);
      if (op == OP_STA) st_q.push_back(pre.acc);
      op_valid = 1'b1;
      opcode   = op;
      operand  = val;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      opcode   = OP_NOP;
      operand  = '0;
      is_alu   = (op inside {OP_ADD, OP_ADC, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_SHL});
      if (is_alu) begin
         check_val("exec_ready", 32'(op_ready), 32'd0);
         check_val("exec_ctrl", 32'(alu_ctrl), 32'(ctrl_of(op)));
         check_val("exec_in0", 32'(alu_in0), 32'(pre.acc));
         if (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SHL}) begin
            check_val("exec_in1", 32'(alu_in1), 32'((op == OP_SHL) ? pre.acc : val));
            check_val("exec_cin", 32'(alu_cin),
                      32'((op == OP_SUB) ? 1'b1 : (op == OP_ADC) ? pre.c : 1'b0));
         end
         @(posedge clk);
         #1;
      end
      e = sb_q.pop_front();
      check_val("acc", 32'(acc), 32'(e.acc));
      check_val("flag_c", 32'(flag_c), 32'(e.c));
      check_val("flag_v", 32'(flag_v), 32'(e.v));
      check_val("flag_z", 32'(flag_z), 32'(e.z));
      if (op == OP_STA) begin
         check_val("sta_valid", 32'(st_valid), 32'd1);
         check_val("sta_data", 32'(st_data), 32'(pre.acc));
         check_val("sta_ready", 32'(op_ready), 32'd0);
      end else begin
         check_val("done_ready", 32'(op_ready), 32'd1);
         check_val("idle_ctrl", 32'(alu_ctrl), 32'd0);
         check_val("idle_in1", 32'(alu_in1), 32'd0);
         check_val("idle_cin", 32'(alu_cin), 32'd0);
         check_val("illegal_pulse", 32'(illegal), 32'(op > OP_SHL));
         if (op > OP_SHL) begin
            @(posedge clk);
            #1;
            check_val("illegal_clear", 32'(illegal), 32'd0);
         end
      end
      $display("op=%0d operand=%0h -> acc=%0h c=%0b v=%0b z=%0b", op, val, acc, flag_c, flag_v, flag_z);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      m_state  = '0;
      rst_n    = 1'b0;
      op_valid = 1'b0;
      opcode   = OP_NOP;
      operand  = '0;
      st_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready", 32'(op_ready), 32'd0);
      check_val("rst_acc", 32'(acc), 32'd0);
      check_val("rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
      check_val("rst_st_valid", 32'(st_valid), 32'd0);
      check_val("rst_illegal", 32'(illegal), 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rel_ready", 32'(op_ready), 32'd1);

      // ADD with wrap
      issue(OP_LDA, 4'd7);
      issue(OP_ADD, 4'd9);
      check_val("t1_acc", 32'(acc), 32'd0);
      check_val("t1_cvz", 32'({flag_c, flag_v, flag_z}), 32'b101);

      // Overflow, then ADC with C clear and with C set
      issue(OP_LDA, 4'd7);
      issue(OP_ADD, 4'd1);
      check_val("t2_acc8", 32'(acc), 32'd8);
      check_val("t2_v", 32'(flag_v), 32'd1);
      issue(OP_CLC, 4'd0);
      issue(OP_LDA, 4'd3);
      issue(OP_ADC, 4'd4);
      check_val("t2_adc0", 32'(acc), 32'd7);
      issue(OP_LDA, 4'd15);
      issue(OP_ADD, 4'd1);
      issue(OP_LDA, 4'd3);
      issue(OP_ADC, 4'd4);
      check_val("t2_adc1", 32'(acc), 32'd8);

      // SUB to zero, then logic op holds C
      issue(OP_LDA, 4'd5);
      issue(OP_SUB, 4'd5);
      check_val("t3_sub_cvz", 32'({flag_c, flag_v, flag_z}), 32'b101);
      issue(OP_LDA, 4'd6);
      issue(OP_AND, 4'd3);
      check_val("t3_and", 32'(acc), 32'd2);
      check_val("t3_c_hold", 32'(flag_c), 32'd1);

      issue(OP_LDA, 4'd9);
      issue(OP_OR, 4'd6);
      issue(OP_NOT, 4'd0);
      issue(OP_LDA, 4'd9);
      issue(OP_SHL, 4'd0);

      // Store backpressure
      issue(OP_LDA, 4'd10);
      st_ready = 1'b0;
      issue(OP_STA, 4'd0);
      for (int i = 0; i < 4; i++) begin
         check_val("bp_valid", 32'(st_valid), 32'd1);
         check_val("bp_data", 32'(st_data), 32'd10);
         check_val("bp_ready", 32'(op_ready), 32'd0);
         if (i == 3) st_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      check_val("bp_ready_after", 32'(op_ready), 32'd1);
      check_val("bp_valid_after", 32'(st_valid), 32'd0);

      // Illegal opcode
      issue(OP_LDA, 4'd9);
      issue(4'd13, 4'd5);
      check_val("ill_acc", 32'(acc), 32'd9);

      for (int k = 0; k < 40; k++) begin
         issue(4'($urandom_range(0, 10)), N'($urandom_range(0, 15)));
      end

      // Asynchronous reset during EXEC
      issue(OP_LDA, 4'd3);
      op_valid = 1'b1;
      opcode   = OP_ADD;
      operand  = 4'd4;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      opcode   = OP_NOP;
      operand  = '0;
      check_val("mid_in_exec", 32'(op_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      m_state = '0;
      check_val("mid_rst_acc", 32'(acc), 32'd0);
      check_val("mid_rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
      check_val("mid_rst_ready", 32'(op_ready), 32'd0);
      check_val("mid_rst_in1", 32'(alu_in1), 32'd0);
      @(posedge clk);
      #1;
      check_val("mid_hold_ready", 32'(op_ready), 32'd0);
      #3 rst_n = 1'b1;
      #1;
      check_val("mid_rel_ready0", 32'(op_ready), 32'd0);
      @(posedge clk);
      #1;
      check_val("mid_rel_ready1", 32'(op_ready), 32'd1);
      check_val("mid_rel_acc", 32'(acc), 32'd0);
      @(posedge clk);
      #1;
      check_val("no_stale_acc", 32'(acc), 32'd0);
      check_val("no_stale_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
      issue(OP_ADD, 4'd2);

      check_val("st_q_drained", 32'(st_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
